// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - command sequencer driving a 4-bit universal shift register
//
// Accepts one command per valid/ready handshake (parallel load, rotate left,
// rotate right, no-op). It drives the register mode selects and load data,
// and counts out the required number of rotate cycles. It keeps a shadow copy
// of the expected register contents and pulses DONE for one cycle when a
// command completes.
//
// Optional build macro: SHIFT_CTRL_CHECK_EN
//   defined     - {Q3..Q0} is compared against SHADOW in every DONE cycle.
//                 A difference sets the sticky MISMATCH flag, which stays set
//                 until RST.
//   not defined - Q3..Q0 are ignored and MISMATCH is tied to 0.
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   CMD_VALID/READY command handshake (READY high only in IDLE)
//   CMD_OP          00 load, 01 rotate left, 10 rotate right, 11 no-op
//   CMD_DATA        load value (bit 3 = MSB)
//   CMD_CNT         rotate step count (0 completes immediately)
//   S1, S0          register mode select: 00 rol, 01 ror, 10 hold, 11 load
//   D3..D0          register parallel-load data
//   Q3..Q0          register outputs (checked only with SHIFT_CTRL_CHECK_EN)
//   SHADOW          expected register contents, {Q3..Q0} order
//   BUSY            high whenever the FSM is not in IDLE
//   DONE            one-cycle completion pulse
//   MISMATCH        sticky check failure flag
module shift_reg_ctrl #(
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [3:0]       CMD_DATA,
    input  logic [CNT_W-1:0] CMD_CNT,
    output logic             S1,
    output logic             S0,
    output logic             D3,
    output logic             D2,
    output logic             D1,
    output logic             D0,
    input  logic             Q3,
    input  logic             Q2,
    input  logic             Q1,
    input  logic             Q0,
    output logic [3:0]       SHADOW,
    output logic             BUSY,
    output logic             DONE,
    output logic             MISMATCH
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ROL  = 2'b01;
    localparam logic [1:0] OP_ROR  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [1:0] SEL_ROL  = 2'b00;
    localparam logic [1:0] SEL_ROR  = 2'b01;
    localparam logic [1:0] SEL_HOLD = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       data_q, data_d;
    logic [3:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             mismatch_q, mismatch_d;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        data_d     = data_q;
        shadow_d   = shadow_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;

        case (state_q)
            ST_IDLE: begin
                sel_d = SEL_HOLD;
                // CMD_READY is implied by being in IDLE
                if (CMD_VALID) begin
                    case (CMD_OP)
                        OP_LOAD: begin
                            data_d  = CMD_DATA;
                            sel_d   = SEL_LOAD;
                            state_d = ST_LOAD;
                        end
                        OP_ROL, OP_ROR: begin
                            if (CMD_CNT != CNT_ZERO) begin
                                cnt_d   = CMD_CNT;
                                sel_d   = (CMD_OP == OP_ROL) ? SEL_ROL : SEL_ROR;
                                state_d = ST_SHIFT;
                            end else begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end
                        default: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end

            ST_LOAD: begin
                // The register samples D on this edge, so the shadow follows it
                shadow_d = data_q;
                sel_d    = SEL_HOLD;
                state_d  = ST_DONE;
                done_d   = 1'b1;
            end

            ST_SHIFT: begin
                // sel_q still carries the commanded direction throughout SHIFT
                if (sel_q[0]) begin
                    shadow_d = {shadow_q[0], shadow_q[3:1]};
                end else begin
                    shadow_d = {shadow_q[2:0], shadow_q[3]};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    sel_d   = SEL_HOLD;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            ST_DONE: begin
`ifdef SHIFT_CTRL_CHECK_EN
                if ({Q3, Q2, Q1, Q0} != shadow_q) begin
                    mismatch_d = 1'b1;
                end
`endif
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_HOLD;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_HOLD;
            data_q     <= 4'b0000;
            shadow_q   <= 4'b0000;
            cnt_q      <= CNT_ZERO;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign CMD_READY = (state_q == ST_IDLE);
    assign BUSY      = (state_q != ST_IDLE);
    assign S1        = sel_q[1];
    assign S0        = sel_q[0];
    assign D3        = data_q[3];
    assign D2        = data_q[2];
    assign D1        = data_q[1];
    assign D0        = data_q[0];
    assign SHADOW    = shadow_q;
    assign DONE      = done_q;

`ifdef SHIFT_CTRL_CHECK_EN
    assign MISMATCH = mismatch_q;
`else
    // Without the check the register outputs have no consumer
    logic unused_q;
    logic unused_mismatch;
    assign unused_q        = ^{Q3, Q2, Q1, Q0};
    assign unused_mismatch = mismatch_q;
    assign MISMATCH        = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - directed self-checking bench for shift_reg_ctrl
module tb_shift_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_cnt;
    logic       s1, s0, d3, d2, d1, d0;
    logic       q3, q2, q1, q0;
    logic [3:0] shadow;
    logic       busy, done, mismatch;
    logic [3:0] mq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_reg_ctrl #(.CNT_W(3)) dut (
        .CLK(clk), .RST(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_OP(cmd_op), .CMD_DATA(cmd_data), .CMD_CNT(cmd_cnt),
        .S1(s1), .S0(s0), .D3(d3), .D2(d2), .D1(d1), .D0(d0),
        .Q3(q3), .Q2(q2), .Q1(q1), .Q0(q0),
        .SHADOW(shadow), .BUSY(busy), .DONE(done), .MISMATCH(mismatch)
    );

    // Behavioural 4-bit universal shift register downstream of the DUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mq <= 4'b0000;
        else begin
            case ({s1, s0})
                2'b00:   mq <= {mq[2:0], mq[3]};
                2'b01:   mq <= {mq[0], mq[3:1]};
                2'b11:   mq <= {d3, d2, d1, d0};
                default: mq <= mq;
            endcase
        end
    end

    assign q3 = mq[3];
    assign q2 = mq[2];
    assign q1 = mq[1];
`ifdef SHIFT_CTRL_CHECK_EN
    logic q0_stuck = 1'b0;
    assign q0 = q0_stuck ? 1'b0 : mq[0];
`else
    assign q0 = mq[0];
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and let the next edge accept it; returns in cycle 1
    task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'b0000;
        cmd_cnt   = 3'd0;
        #2;
        check("rst_sel",    {s1, s0}, 2'b10);
        check("rst_d",      {d3, d2, d1, d0}, 4'b0000);
        check("rst_shadow", shadow, 4'b0000);
        check("rst_done",   done, 1'b0);
        check("rst_mism",   mismatch, 1'b0);
        check("rst_ready",  cmd_ready, 1'b1);
        check("rst_busy",   busy, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Load 1001: S=11 in cycle 1, DONE in cycle 2
        issue(2'b00, 4'b1001, 3'd5);
        check("ld_c1_sel",   {s1, s0}, 2'b11);
        check("ld_c1_d",     {d3, d2, d1, d0}, 4'b1001);
        check("ld_c1_done",  done, 1'b0);
        check("ld_c1_ready", cmd_ready, 1'b0);
        check("ld_c1_busy",  busy, 1'b1);
        tick();
        check("ld_c2_done",   done, 1'b1);
        check("ld_c2_sel",    {s1, s0}, 2'b10);
        check("ld_c2_shadow", shadow, 4'b1001);
        check("ld_c2_q",      mq, 4'b1001);
        tick();
        check("ld_idle_done",  done, 1'b0);
        check("ld_idle_ready", cmd_ready, 1'b1);

        // Rotate left 1: 1001 -> 0011, DONE in cycle 2
        issue(2'b01, 4'b0000, 3'd1);
        check("rl1_c1_sel",  {s1, s0}, 2'b00);
        check("rl1_c1_done", done, 1'b0);
        tick();
        check("rl1_c2_done",   done, 1'b1);
        check("rl1_c2_shadow", shadow, 4'b0011);
        check("rl1_c2_q",      mq, 4'b0011);
        check("rl1_c2_sel",    {s1, s0}, 2'b10);
        tick();

        // Reload 1001, rotate right 3: 1001->1100->0110->0011, DONE in cycle 4
        issue(2'b00, 4'b1001, 3'd0);
        tick();
        tick();
        issue(2'b10, 4'b0000, 3'd3);
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("rr3_c%0d_sel", i), {s1, s0}, 2'b01);
            check($sformatf("rr3_c%0d_ready", i), cmd_ready, 1'b0);
            check($sformatf("rr3_c%0d_done", i), done, 1'b0);
            tick();
        end
        check("rr3_c4_done",   done, 1'b1);
        check("rr3_c4_shadow", shadow, 4'b0011);
        check("rr3_c4_q",      mq, 4'b0011);
        check("rr3_c4_ready",  cmd_ready, 1'b0);
        tick();

        // Zero-count rotate, with a no-op held valid during DONE
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_cnt   = 3'd0;
        tick();
        cmd_op = 2'b11;
        check("z_c1_done",   done, 1'b1);
        check("z_c1_sel",    {s1, s0}, 2'b10);
        check("z_c1_shadow", shadow, 4'b0011);
        check("z_c1_ready",  cmd_ready, 1'b0);
        tick();
        check("z_idle_done",  done, 1'b0);
        check("z_idle_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("nop_c1_done",   done, 1'b1);
        check("nop_c1_sel",    {s1, s0}, 2'b10);
        check("nop_c1_shadow", shadow, 4'b0011);
        tick();
        check("nop_idle_done", done, 1'b0);

        // Maximum count 7 left from 0011: equivalent to one right -> 1001
        issue(2'b01, 4'b0000, 3'd7);
        for (int i = 1; i <= 7; i++) begin
            check($sformatf("rl7_c%0d_sel", i), {s1, s0}, 2'b00);
            check($sformatf("rl7_c%0d_done", i), done, 1'b0);
            tick();
        end
        check("rl7_c8_done",   done, 1'b1);
        check("rl7_c8_shadow", shadow, 4'b1001);
        check("rl7_c8_q",      mq, 4'b1001);
        tick();
        check("rl7_mism", mismatch, 1'b0);

        // Reset mid-SHIFT: load 1111, rotate left 5, reset after 2 shift cycles
        issue(2'b00, 4'b1111, 3'd0);
        tick();
        tick();
        issue(2'b01, 4'b0000, 3'd5);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mrst_sel",    {s1, s0}, 2'b10);
        check("mrst_shadow", shadow, 4'b0000);
        check("mrst_done",   done, 1'b0);
        check("mrst_busy",   busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("mrst_hold%0d_done", i), done, 1'b0);
        end
        rst = 1'b0;
        tick();
        check("mrst_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("mrst_after%0d_done", i), done, 1'b0);
        end

`ifdef SHIFT_CTRL_CHECK_EN
        // Q0 stuck at 0 while loading 0001 must set the sticky flag
        q0_stuck = 1'b1;
        issue(2'b00, 4'b0001, 3'd0);
        tick();
        check("chk_done_cycle_mism", mismatch, 1'b0);
        tick();
        check("chk_mism_set", mismatch, 1'b1);
        issue(2'b11, 4'b0000, 3'd0);
        tick();
        check("chk_mism_sticky", mismatch, 1'b1);
        rst = 1'b1;
        #1;
        check("chk_mism_rst", mismatch, 1'b0);
        rst = 1'b0;
        q0_stuck = 1'b0;
        tick();
`else
        issue(2'b00, 4'b0001, 3'd0);
        tick();
        tick();
        check("nochk_mism", mismatch, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
